// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, receiver state encoding and a 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; RESET_VAL is the level held through reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART frame receiver with start-glitch rejection, optional parity and 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around every sample point.
//
// state  | meaning
// IDLE   | line idle; waits for a falling edge once the line has been seen high (armed)
// START  | verifies the start bit at its mid-point; a high sample is a glitch
// DATA   | samples DATA_SIZE bits, LSB first
// PARITY | samples the parity bit and compares against the received data
// STOP   | samples STOP_BITS stop bits; the last one completes the frame
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int DATA_SIZE      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out
);

  localparam int HALF = CLK_BAUD_RATIO / 2;
  localparam int CW   = $clog2(CLK_BAUD_RATIO);
  localparam int IW   = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] TGT_START = CW'(HALF - 1);
  localparam logic [CW-1:0] TGT_BIT   = CW'(CLK_BAUD_RATIO - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_SIZE - 1);
  localparam logic PAR_EN    = (PARITY_MODE != int'(PAR_NONE));
  localparam logic PAR_INV   = (PARITY_MODE == int'(PAR_ODD));
  localparam logic LAST_STOP = (STOP_BITS == 2);

  rx_state_t state, state_nxt;
  logic [CW-1:0] cnt, tgt;
  logic [IW-1:0] bit_idx;
  logic [DATA_SIZE-1:0] shift;
  logic rx_s, armed, perr, ferr, stop_idx;
  logic at_tgt, smp_evt, smp_bit, start_det;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .d       (rx_in),
    .q       (rx_s)
  );

  assign tgt       = (state == START) ? TGT_START : TGT_BIT;
  assign at_tgt    = (state != IDLE) && (cnt == tgt);
  assign start_det = (state == IDLE) && armed && !rx_s;

`ifdef UART_RX_MAJORITY_EN
  // The counter still wraps at target; the vote resolves one cycle later, keeping bit periods intact.
  logic s_early, s_tgt, pend;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s_early <= 1'b1;
      s_tgt   <= 1'b1;
      pend    <= 1'b0;
    end else begin
      pend <= at_tgt;
      if ((state != IDLE) && (cnt == tgt - CW'(1))) s_early <= rx_s;
      if (at_tgt) s_tgt <= rx_s;
    end
  end

  assign smp_evt = pend;
  assign smp_bit = maj3(s_early, s_tgt, rx_s);
`else
  assign smp_evt = at_tgt;
  assign smp_bit = rx_s;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (smp_evt) state_nxt = smp_bit ? IDLE : DATA;
      DATA:    if (smp_evt && (bit_idx == LAST_IDX)) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY:  if (smp_evt) state_nxt = STOP;
      STOP:    if (smp_evt && (stop_idx == LAST_STOP)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt <= '0;
    else if ((state == IDLE) || at_tgt) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out       <= '0;
      valid_out      <= 1'b0;
      busy_out       <= 1'b0;
      parity_err_out <= 1'b0;
      frame_err_out  <= 1'b0;
      shift          <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      armed          <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_det) busy_out <= 1'b1;
        end
        START: begin
          if (smp_evt) begin
            if (smp_bit) begin
              busy_out <= 1'b0;
            end else begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
            end
          end
        end
        DATA: begin
          if (smp_evt) begin
            shift[bit_idx] <= smp_bit;
            bit_idx        <= bit_idx + IW'(1);
          end
        end
        PARITY: begin
          if (smp_evt) perr <= smp_bit ^ (^shift) ^ PAR_INV;
        end
        STOP: begin
          if (smp_evt) begin
            if (stop_idx == LAST_STOP) begin
              data_out       <= shift;
              parity_err_out <= perr;
              frame_err_out  <= ferr | ~smp_bit;
              valid_out      <= 1'b1;
              busy_out       <= 1'b0;
              // A low final stop (break) must see the line return high before re-arming.
              armed          <= smp_bit;
            end else begin
              ferr     <= ferr | ~smp_bit;
              stop_idx <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (8N1, even parity, two stop bits) with per-instance scoreboards.
module tb_uart_rx_frame;

  localparam int CBR = 25;
  // Two synchroniser flops plus the edge on which IDLE sees rx_s low.
  localparam int SYNC_DETECT = 3;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
  localparam logic [7:0] SPIKE_EXP = 8'h3C;
`else
  localparam int MAJ = 0;
  localparam logic [7:0] SPIKE_EXP = 8'hC3;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rx_def, rx_par, rx_s2;
  logic [7:0] data_def, data_par, data_s2;
  logic valid_def, valid_par, valid_s2;
  logic busy_def, busy_par, busy_s2;
  logic perr_def, perr_par, perr_s2;
  logic ferr_def, ferr_par, ferr_s2;

  exp_t q_def[$], q_par[$], q_s2[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int vcnt_def = 0, vcnt_par = 0, vcnt_s2 = 0;
  int vcyc_last_def = 0, vcyc_prev_def = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  uart_rx_frame dut_def (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_def), .data_out(data_def),
    .valid_out(valid_def), .busy_out(busy_def), .parity_err_out(perr_def), .frame_err_out(ferr_def)
  );

  uart_rx_frame #(.PARITY_MODE(1)) dut_par (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_par), .data_out(data_par),
    .valid_out(valid_par), .busy_out(busy_par), .parity_err_out(perr_par), .frame_err_out(ferr_par)
  );

  uart_rx_frame #(.STOP_BITS(2)) dut_s2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_s2), .data_out(data_s2),
    .valid_out(valid_s2), .busy_out(busy_s2), .parity_err_out(perr_s2), .frame_err_out(ferr_s2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (valid_def) begin
      vcnt_def++;
      vcyc_prev_def = vcyc_last_def;
      vcyc_last_def = cyc;
      chk("def_valid_expected", 32'(q_def.size() > 0), 32'd1);
      if (q_def.size() > 0) begin
        e = q_def.pop_front();
        chk("def_data", 32'(data_def), 32'(e.data));
        chk("def_perr", 32'(perr_def), 32'(e.perr));
        chk("def_ferr", 32'(ferr_def), 32'(e.ferr));
      end
    end
    if (valid_par) begin
      vcnt_par++;
      chk("par_valid_expected", 32'(q_par.size() > 0), 32'd1);
      if (q_par.size() > 0) begin
        e = q_par.pop_front();
        chk("par_data", 32'(data_par), 32'(e.data));
        chk("par_perr", 32'(perr_par), 32'(e.perr));
        chk("par_ferr", 32'(ferr_par), 32'(e.ferr));
      end
    end
    if (valid_s2) begin
      vcnt_s2++;
      chk("s2_valid_expected", 32'(q_s2.size() > 0), 32'd1);
      if (q_s2.size() > 0) begin
        e = q_s2.pop_front();
        chk("s2_data", 32'(data_s2), 32'(e.data));
        chk("s2_perr", 32'(perr_s2), 32'(e.perr));
        chk("s2_ferr", 32'(ferr_s2), 32'(e.ferr));
      end
    end
  end

  task automatic hold(input int which, input logic v, input int n);
    case (which)
      0:       rx_def = v;
      1:       rx_par = v;
      default: rx_s2  = v;
    endcase
    repeat (n) @(negedge clk_in);
  endtask

  // par_bit < 0 means no parity bit; spike inverts one cycle at the middle of every data bit.
  task automatic send_frame(input int which, input logic [7:0] d, input int par_bit,
                            input int nstop, input logic stop_last, input logic spike);
    logic b;
    hold(which, 1'b0, CBR);
    for (int i = 0; i < 8; i++) begin
      b = d[i];
      if (spike) begin
        hold(which, b, 12);
        hold(which, ~b, 1);
        hold(which, b, CBR - 13);
      end else begin
        hold(which, b, CBR);
      end
    end
    if (par_bit >= 0) hold(which, par_bit[0], CBR);
    for (int s = 0; s < nstop; s++) hold(which, (s == nstop - 1) ? stop_last : 1'b1, CBR);
  endtask

  initial begin
    int k, base;
    rst_n_in = 1'b0;
    rx_def = 1'b1; rx_par = 1'b1; rx_s2 = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_data", 32'(data_def), 32'd0);
    chk("rst_valid", 32'(valid_def), 32'd0);
    chk("rst_busy", 32'(busy_def), 32'd0);
    chk("rst_perr", 32'(perr_def), 32'd0);
    chk("rst_ferr", 32'(ferr_def), 32'd0);
    rst_n_in = 1'b1;
    hold(0, 1'b1, 2 * CBR);

    // 0xA5, 8N1, plus latency from the rx_in fall.
    k = cyc;
    q_def.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(0, 8'hA5, -1, 1, 1'b1, 1'b0);
    hold(0, 1'b1, CBR);
    chk("a5_count", 32'(vcnt_def), 32'd1);
    chk("a5_latency", 32'(vcyc_last_def - k), 32'(SYNC_DETECT + 12 + 9 * CBR + MAJ));

    // 5-cycle start glitch.
    base = vcnt_def;
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 3);
    chk("glitch_busy_in_start", 32'(busy_def), 32'd1);
    hold(0, 1'b1, 20);
    chk("glitch_busy_cleared", 32'(busy_def), 32'd0);
    hold(0, 1'b1, 10 * CBR);
    chk("glitch_no_valid", 32'(vcnt_def), 32'(base));

    // Even parity on 0x03: parity bit 1 is wrong, 0 is right.
    q_par.push_back('{8'h03, 1'b1, 1'b0});
    send_frame(1, 8'h03, 1, 1, 1'b1, 1'b0);
    hold(1, 1'b1, CBR);
    q_par.push_back('{8'h03, 1'b0, 1'b0});
    send_frame(1, 8'h03, 0, 1, 1'b1, 1'b0);
    hold(1, 1'b1, CBR);
    chk("par_count", 32'(vcnt_par), 32'd2);

    // Two stop bits, second low, then a held break.
    q_s2.push_back('{8'h5A, 1'b0, 1'b1});
    send_frame(2, 8'h5A, -1, 2, 1'b0, 1'b0);
    chk("s2_ferr_count", 32'(vcnt_s2), 32'd1);
    hold(2, 1'b0, 40 * CBR);
    chk("s2_break_no_valid", 32'(vcnt_s2), 32'd1);
    chk("s2_break_not_busy", 32'(busy_s2), 32'd0);
    hold(2, 1'b1, CBR);
    q_s2.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(2, 8'h11, -1, 2, 1'b1, 1'b0);
    hold(2, 1'b1, CBR);
    chk("s2_rearm_count", 32'(vcnt_s2), 32'd2);

    // Back-to-back frames.
    base = vcnt_def;
    q_def.push_back('{8'h00, 1'b0, 1'b0});
    q_def.push_back('{8'hFF, 1'b0, 1'b0});
    send_frame(0, 8'h00, -1, 1, 1'b1, 1'b0);
    send_frame(0, 8'hFF, -1, 1, 1'b1, 1'b0);
    hold(0, 1'b1, CBR);
    chk("b2b_count", 32'(vcnt_def), 32'(base + 2));
    chk("b2b_spacing", 32'(vcyc_last_def - vcyc_prev_def), 32'(10 * CBR));

    // Reset in the middle of data bit 3.
    base = vcnt_def;
    hold(0, 1'b0, CBR);
    hold(0, 1'b1, 2 * CBR);
    hold(0, 1'b0, 10);
    chk("midframe_busy", 32'(busy_def), 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_data", 32'(data_def), 32'd0);
    chk("midrst_busy", 32'(busy_def), 32'd0);
    chk("midrst_valid", 32'(valid_def), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    hold(0, 1'b1, 3 * CBR);
    chk("midrst_no_valid", 32'(vcnt_def), 32'(base));
    q_def.push_back('{8'h96, 1'b0, 1'b0});
    send_frame(0, 8'h96, -1, 1, 1'b1, 1'b0);
    hold(0, 1'b1, CBR);
    chk("post_rst_count", 32'(vcnt_def), 32'(base + 1));

    // Mid-bit spikes: rejected only with majority sampling.
    q_def.push_back('{SPIKE_EXP, 1'b0, 1'b0});
    send_frame(0, 8'h3C, -1, 1, 1'b1, 1'b1);
    hold(0, 1'b1, 2 * CBR);

    chk("def_queue_drained", 32'(q_def.size()), 32'd0);
    chk("par_queue_drained", 32'(q_par.size()), 32'd0);
    chk("s2_queue_drained", 32'(q_s2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART frame receiver: the next generation of the fixed 8N1 receiver used on the host comms link.
- Adds an input synchroniser, mid-bit sampling started from the start-bit edge, start-glitch rejection, optional parity, 1 or 2 stop bits, and parity/framing error reporting.
- Sits between the board RX pin and the command/weight-load parser; drives the same data/valid/busy contract.

Parameters:
- CLK_BAUD_RATIO, 25: clk_in cycles per bit. Must be at least 4.
- DATA_SIZE, 8: data bits per frame, LSB first. Range 5..16.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk_in  input  1  system clock; one clock domain.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- rx_in  input  1  asynchronous serial line; idles high.
- data_out  output  DATA_SIZE  last received word.
- valid_out  output  1  one-cycle pulse: new word on data_out.
- busy_out  output  1  frame in progress.
- parity_err_out  output  1  parity mismatch on the last frame; 0 when PARITY_MODE = 0.
- frame_err_out  output  1  a stop bit was sampled low on the last frame.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, counters 0, sync flops 1, armed 0. Reset mid-frame aborts the frame with no valid_out.
- Synchroniser: rx_in passes through 2 flops to give rx_s, a fixed 2-cycle delay. All decisions below use rx_s.
- HALF = CLK_BAUD_RATIO/2, integer division. The baud counter is $clog2(CLK_BAUD_RATIO) bits wide.
- IDLE:
  - armed <= 1 whenever rx_s = 1.
  - If armed and rx_s = 0: go to START, counter <= 0, busy_out <= 1.
  - The armed flag stops a held-low line from retriggering.
- START: when counter = HALF-1, sample rx_s.
  - Sample 1: glitch; go to IDLE, busy_out <= 0, no valid_out.
  - Sample 0: counter <= 0, go to DATA, bit index <= 0.
- DATA, PARITY and STOP each sample rx_s when counter = CLK_BAUD_RATIO-1, then counter <= 0. The counter otherwise increments.
- DATA: the sample goes into shift bit[index], LSB first. After DATA_SIZE samples, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY:
  - expected bit = XOR of the data bits, inverted for odd parity.
  - perr <= (sample != expected).
- STOP: STOP_BITS samples; ferr is set if any sample is 0.
- Completion, at the edge that takes the last stop sample:
  - data_out, parity_err_out and frame_err_out update together.
  - valid_out <= 1 for exactly one cycle. It is asserted even if an error flag is set.
  - busy_out <= 0, state IDLE.
  - armed <= the current stop sample, so a low stop bit (break) needs the line to go high before a new frame.
- Outputs hold their values until the next completion. Error flags are overwritten, not sticky.
- Latency: valid_out is high in the cycle starting HALF + (DATA_SIZE + P + STOP_BITS)·CLK_BAUD_RATIO cycles after the first cycle with rx_s = 0. P is 1 if parity is enabled, else 0.
- Back-to-back frames: IDLE is entered at mid-stop, so a start edge arriving half a bit later is accepted.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point takes rx_s at counter = target-1, target and target+1 (target is HALF-1 in START, CLK_BAUD_RATIO-1 elsewhere).
  - The 2-of-3 majority is the sampled value, taken at the edge where counter = target+1. The state transition happens at that edge.
  - Bit-period counting is unchanged and the total latency increases by 1 cycle.
- Undefined: single sample at target, as above.

Decomposition:
- Package uart_pkg:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Shared with the future uart_tx_frame.
- Sub-module sync_2ff: a 2-flop synchroniser with async active-low reset and a reset value parameter. It is reused for other pin inputs.

Test Plan:
- Frame 0xA5 (default parameters, 8N1, LSB first, 25 cycles/bit) -> one valid_out pulse, data_out = 0xA5, both error flags 0, valid_out exactly 12 + 9·25 = 237 cycles after rx_s falls.
- 5-cycle low glitch on an idle line -> returns to IDLE at the START sample, no valid_out, busy_out high only during START.
- PARITY_MODE = 1, frame 0x03 with parity bit 1 -> data_out = 0x03, parity_err_out = 1. The same frame with parity bit 0 -> parity_err_out = 0.
- STOP_BITS = 2, second stop bit low on 0x5A -> valid_out, data_out = 0x5A, frame_err_out = 1. Line then held low for 40 bit-times -> no further valid_out until the line goes high and falls again.
- Two back-to-back 0x00/0xFF frames with a single stop bit -> two pulses, 250 cycles apart, values correct. rst_n_in pulsed low in the middle of the data bits of a third frame -> all outputs 0 immediately, no valid_out, the next frame is received correctly.
- With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted spike at each data mid-point of 0x3C -> data_out = 0x3C.
